seg_bcd_display: RTL and testbench

SEG_BCD_DISPLAY -- requirements
Module: seg_bcd_display

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_hex_encode.sv | 32 +++
 rtl/seg_bcd_display.sv | 154 +++++++++++++++
 tb/tb_seg_bcd_display.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the BCD 7-segment display: segment constants,
// the active-low 0-9 code table and the controller state type.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_hex_encode.sv
// One digit of segment encoding: a BCD nibble plus a blank request in,
// an active-low 7-segment code out. Non-decimal nibbles show a dash.
module seg_hex_encode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_TABLE[0];
        4'd1:    seg = SEG_TABLE[1];
        4'd2:    seg = SEG_TABLE[2];
        4'd3:    seg = SEG_TABLE[3];
        4'd4:    seg = SEG_TABLE[4];
        4'd5:    seg = SEG_TABLE[5];
        4'd6:    seg = SEG_TABLE[6];
        4'd7:    seg = SEG_TABLE[7];
        4'd8:    seg = SEG_TABLE[8];
        4'd9:    seg = SEG_TABLE[9];
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_bcd_display.sv
// Serial double-dabble binary-to-BCD converter driving DIGITS 7-segment digits.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_bcd_display
  import seg_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(BIN_W - 1);
  localparam logic [7*DIGITS-1:0] ALL_DASH  = {DIGITS{SEG_DASH}};

  state_t              state, next_state;
  logic [BIN_W-1:0]    shift_bin;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    step;
  logic                ovf_sticky;
  logic [7*DIGITS-1:0] hex_reg;
  logic                ovf_reg;
  logic                done_reg;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W:0]   shifted;
  logic                   carry;
  logic [BCD_W-1:0]       bcd_next;
  logic [BIN_W-1:0]       bin_next;
  logic [DIGITS-1:0]      blank_vec;
  logic [7*DIGITS-1:0]    enc_hex;

  assign in_ready = (state == IDLE);
  assign busy     = (state == CONV) || (state == SHOW);
  assign hex      = hex_reg;
  assign ovf      = ovf_reg;
  assign done     = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) next_state = CONV;
        CONV:    if (step == LAST_STEP) next_state = SHOW;
        SHOW:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // One double-dabble step: correct each nibble, then shift BCD:binary left.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
    shifted  = {bcd_adj, shift_bin, 1'b0};
    carry    = shifted[BCD_W+BIN_W];
    bcd_next = shifted[BCD_W+BIN_W-1 -: BCD_W];
    bin_next = shifted[BIN_W-1:0];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is blank while every digit from the top down to it is zero.
  always_comb begin
    logic lead_zero;
    blank_vec = '0;
    lead_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead_zero    = lead_zero && (bcd[4*k +: 4] == 4'd0);
      blank_vec[k] = lead_zero;
    end
  end
`else
  assign blank_vec = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_enc
    seg_hex_encode u_enc (
      .bcd   (bcd[4*k +: 4]),
      .blank (blank_vec[k]),
      .seg   (enc_hex[7*k +: 7])
    );
  end

  // Clear outranks everything else and leaves the display dashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_bin  <= '0;
      bcd        <= '0;
      step       <= '0;
      ovf_sticky <= 1'b0;
      hex_reg    <= ALL_DASH;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (clear) begin
        shift_bin  <= '0;
        bcd        <= '0;
        step       <= '0;
        ovf_sticky <= 1'b0;
        hex_reg    <= ALL_DASH;
        ovf_reg    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              shift_bin  <= in_data;
              bcd        <= '0;
              step       <= '0;
              ovf_sticky <= 1'b0;
            end
          end
          CONV: begin
            bcd       <= bcd_next;
            shift_bin <= bin_next;
            step      <= step + 1'b1;
            if (carry) ovf_sticky <= 1'b1;
          end
          SHOW: begin
            hex_reg  <= ovf_sticky ? ALL_DASH : enc_hex;
            ovf_reg  <= ovf_sticky;
            done_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_bcd_display.sv
// Directed self-checking bench for seg_bcd_display (DIGITS=6, BIN_W=20).
// Expected displays come from decimal arithmetic and a local segment table.
module tb_seg_bcd_display;

  localparam int DIGITS = 6;
  localparam int BIN_W  = 20;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [BIN_W-1:0]    in_data;
  logic                in_ready;
  logic                clear;
  logic [7*DIGITS-1:0] hex;
  logic                busy;
  logic                done;
  logic                ovf;

  int vectors;
  int miscompares;

  seg_bcd_display #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clear    (clear),
    .hex      (hex),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7*DIGITS-1:0] exp_hex(int unsigned v, bit blank_en);
    logic [6:0] codes [10];
    logic [7*DIGITS-1:0] r;
    int unsigned p;
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v > 999999) r[7*k +: 7] = DASH;
      else if (blank_en && k > 0 && v < p) r[7*k +: 7] = BLANK;
      else r[7*k +: 7] = codes[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] all_dash();
    return {DIGITS{DASH}};
  endfunction

  // Transfer one value and count rising edges until done is seen.
  task automatic convert(input int unsigned v, output int cycles);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BIN_W'(v);
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = BIN_W'($urandom);
    cycles = 1;
    @(posedge clk);
    #1;
    while (!done && cycles < 60) begin
      @(posedge clk);
      cycles++;
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in_data = '0;
    #12;
    vectors++;
    if (hex !== all_dash()) begin miscompares++; $display("[TB] FAIL reset_hex: got %h expected %h", hex, all_dash()); end
    vectors++;
    if ({ovf, done, busy} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got ovf/done/busy=%b expected 000", {ovf, done, busy}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int cycles;
    logic [7*DIGITS-1:0] held;
    convert(123456, cycles);
    vectors++;
    if (cycles != BIN_W + 1) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d edges expected %0d", cycles, BIN_W + 1); end
    vectors++;
    if (hex !== exp_hex(123456, BLANK_ON)) begin miscompares++; $display("[TB] FAIL basic_hex: got %h expected %h", hex, exp_hex(123456, BLANK_ON)); end
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_ovf: got %b expected 0", ovf); end
    held = hex;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    vectors++;
    if (hex !== exp_hex(123456, BLANK_ON)) begin miscompares++; $display("[TB] FAIL basic_hold: got %h expected %h", hex, held); end
  endtask

  task automatic test_overflow();
    int cycles;
    convert(999999, cycles);
    vectors++;
    if (hex !== exp_hex(999999, BLANK_ON) || ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL max_value: got %h ovf=%b expected %h ovf=0", hex, ovf, exp_hex(999999, BLANK_ON)); end
    convert(1000000, cycles);
    vectors++;
    if (hex !== all_dash() || ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow: got %h ovf=%b expected %h ovf=1", hex, ovf, all_dash()); end
    vectors++;
    if (cycles != BIN_W + 1) begin miscompares++; $display("[TB] FAIL overflow_latency: got %0d expected %0d", cycles, BIN_W + 1); end
  endtask

  task automatic test_blanking();
    int cycles;
    convert(0, cycles);
    vectors++;
    if (hex !== exp_hex(0, BLANK_ON) || ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_value: got %h ovf=%b expected %h ovf=0", hex, ovf, exp_hex(0, BLANK_ON)); end
    vectors++;
    if (hex[6:0] !== 7'b1000000) begin miscompares++; $display("[TB] FAIL zero_digit0: got %b expected 1000000", hex[6:0]); end
    convert(42, cycles);
    vectors++;
    if (hex !== exp_hex(42, BLANK_ON)) begin miscompares++; $display("[TB] FAIL value_42: got %h expected %h", hex, exp_hex(42, BLANK_ON)); end
  endtask

  task automatic test_reset_mid();
    int cycles;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BIN_W'(654321);
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (hex !== all_dash() || {ovf, done, busy} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_mid: got %h ovf/done/busy=%b expected %h 000", hex, {ovf, done, busy}, all_dash()); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mid_ready: got %b expected 1", in_ready); end
    convert(7, cycles);
    vectors++;
    if (hex !== exp_hex(7, BLANK_ON) || cycles != BIN_W + 1) begin miscompares++; $display("[TB] FAIL after_reset_7: got %h in %0d edges expected %h in %0d", hex, cycles, exp_hex(7, BLANK_ON), BIN_W + 1); end
  endtask

  task automatic test_clear();
    int done_seen;
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = BIN_W'(5);
    @(posedge clk);
    #1;
    vectors++;
    if (hex !== all_dash() || busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_idle: got %h busy=%b ovf=%b done=%b expected %h 0 0 0", hex, busy, ovf, done, all_dash()); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b1; in_data = BIN_W'(300);
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_conv: got busy=%b ready=%b done=%b expected 0 1 0", busy, in_ready, done); end
    @(negedge clk);
    clear = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    vectors++;
    if (done_seen != 0 || hex !== all_dash()) begin miscompares++; $display("[TB] FAIL clear_abort: got %0d done pulses hex %h expected 0 and %h", done_seen, hex, all_dash()); end
  endtask

  task automatic test_back_to_back();
    int n;
    int ready_bad;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BIN_W'(111);
    @(posedge clk);
    #1;
    @(negedge clk);
    in_data = BIN_W'(222);
    n = 1;
    ready_bad = 0;
    @(posedge clk);
    #1;
    while (!done && n < 60) begin
      if (in_ready || !busy) ready_bad++;
      @(posedge clk);
      n++;
      #1;
    end
    vectors++;
    if (n != BIN_W + 1 || ready_bad != 0) begin miscompares++; $display("[TB] FAIL b2b_first: got %0d edges %0d ready errors expected %0d and 0", n, ready_bad, BIN_W + 1); end
    vectors++;
    if (in_ready !== 1'b1 || hex !== exp_hex(111, BLANK_ON)) begin miscompares++; $display("[TB] FAIL b2b_done_cycle: got ready=%b hex %h expected 1 %h", in_ready, hex, exp_hex(111, BLANK_ON)); end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_second_xfer: got busy=%b ready=%b expected 1 0", busy, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    @(posedge clk);
    #1;
    while (!done && n < 60) begin
      @(posedge clk);
      n++;
      #1;
    end
    vectors++;
    if (n != BIN_W + 1 || hex !== exp_hex(222, BLANK_ON)) begin miscompares++; $display("[TB] FAIL b2b_second: got %0d edges hex %h expected %0d %h", n, hex, BIN_W + 1, exp_hex(222, BLANK_ON)); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_blanking();
    test_reset_mid();
    test_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
